// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder writing encoded words into instruction memory
package instr_encoder_pkg;
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, FENCE_I, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } instr_kind_t;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  instr_kind_t       in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic [11:0]       in_csr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);
    typedef enum logic [1:0] {S_EMPTY, S_PEND, S_FULL} state_t;
    typedef enum logic [3:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_C, F_FIX} fmt_t;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    state_t           state_q, state_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             err_q, err_d;
    logic [31:0]      wdata_q, wdata_d;

    fmt_t        fmt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] fix_word, word;
    logic        fix_ok, legal, i_ok, b_ok, j_ok;
    logic        wr_done, accept;

    always_comb begin
        fmt = F_FIX; opc = 7'h00; f3 = 3'd0; f7 = 7'h00;
        fix_word = 32'h0; fix_ok = 1'b1;
        case (in_kind)
            LUI:     begin fmt = F_U;  opc = 7'h37; end
            AUIPC:   begin fmt = F_U;  opc = 7'h17; end
            JAL:     begin fmt = F_J;  opc = 7'h6f; end
            JALR:    begin fmt = F_I;  opc = 7'h67; end
            BEQ:     begin fmt = F_B;  opc = 7'h63; f3 = 3'd0; end
            BNE:     begin fmt = F_B;  opc = 7'h63; f3 = 3'd1; end
            BLT:     begin fmt = F_B;  opc = 7'h63; f3 = 3'd4; end
            BGE:     begin fmt = F_B;  opc = 7'h63; f3 = 3'd5; end
            BLTU:    begin fmt = F_B;  opc = 7'h63; f3 = 3'd6; end
            BGEU:    begin fmt = F_B;  opc = 7'h63; f3 = 3'd7; end
            LB:      begin fmt = F_I;  opc = 7'h03; f3 = 3'd0; end
            LH:      begin fmt = F_I;  opc = 7'h03; f3 = 3'd1; end
            LW:      begin fmt = F_I;  opc = 7'h03; f3 = 3'd2; end
            LBU:     begin fmt = F_I;  opc = 7'h03; f3 = 3'd4; end
            LHU:     begin fmt = F_I;  opc = 7'h03; f3 = 3'd5; end
            SB:      begin fmt = F_S;  opc = 7'h23; f3 = 3'd0; end
            SH:      begin fmt = F_S;  opc = 7'h23; f3 = 3'd1; end
            SW:      begin fmt = F_S;  opc = 7'h23; f3 = 3'd2; end
            ADDI:    begin fmt = F_I;  opc = 7'h13; f3 = 3'd0; end
            SLTI:    begin fmt = F_I;  opc = 7'h13; f3 = 3'd2; end
            SLTIU:   begin fmt = F_I;  opc = 7'h13; f3 = 3'd3; end
            XORI:    begin fmt = F_I;  opc = 7'h13; f3 = 3'd4; end
            ORI:     begin fmt = F_I;  opc = 7'h13; f3 = 3'd6; end
            ANDI:    begin fmt = F_I;  opc = 7'h13; f3 = 3'd7; end
            SLLI:    begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
            SRLI:    begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
            SRAI:    begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            ADD:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; end
            SUB:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            SLL:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd1; end
            SLT:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd2; end
            SLTU:    begin fmt = F_R;  opc = 7'h33; f3 = 3'd3; end
            XOR:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd4; end
            SRL:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; end
            SRA:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            OR:      begin fmt = F_R;  opc = 7'h33; f3 = 3'd6; end
            AND:     begin fmt = F_R;  opc = 7'h33; f3 = 3'd7; end
            FENCE:   fix_word = 32'h0ff0000f;
            FENCE_I: fix_word = 32'h0000100f;
            ECALL:   fix_word = 32'h00000073;
            EBREAK:  fix_word = 32'h00100073;
            CSRRW:   begin fmt = F_C;  opc = 7'h73; f3 = 3'd1; end
            CSRRS:   begin fmt = F_C;  opc = 7'h73; f3 = 3'd2; end
            CSRRC:   begin fmt = F_C;  opc = 7'h73; f3 = 3'd3; end
            CSRRWI:  begin fmt = F_C;  opc = 7'h73; f3 = 3'd5; end
            CSRRSI:  begin fmt = F_C;  opc = 7'h73; f3 = 3'd6; end
            CSRRCI:  begin fmt = F_C;  opc = 7'h73; f3 = 3'd7; end
            default: fix_ok = 1'b0;
        endcase
    end

    assign i_ok = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
    assign b_ok = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
    assign j_ok = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574) && !in_imm[0];

    // CSR immediate forms carry zimm in the rs1 slot, so one layout serves all six
    always_comb begin
        word  = fix_word;
        legal = fix_ok;
        case (fmt)
            F_R:  word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            F_I:  begin word = {in_imm[11:0], in_rs1, f3, in_rd, opc}; legal = i_ok; end
            F_SH: begin word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc}; legal = (in_imm[31:5] == 27'd0); end
            F_S:  begin word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc}; legal = i_ok; end
            F_B:  begin
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
                legal = b_ok;
            end
            F_U:  begin word = {in_imm[31:12], in_rd, opc}; legal = (in_imm[11:0] == 12'd0); end
            F_J:  begin
                word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
                legal = j_ok;
            end
            F_C:  word = {in_csr, in_rs1, f3, in_rd, opc};
            default: ;
        endcase
    end

    // The last free slot cannot take a second word queued behind it, or the address would wrap
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_EMPTY: in_ready = 1'b1;
            S_PEND:  in_ready = mem_ready && (count_q != LAST_CNT);
            default: in_ready = 1'b0;
        endcase
        if (rst || start) in_ready = 1'b0;
    end

    assign wr_done = (state_q == S_PEND) && mem_ready;
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = S_EMPTY;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_done) begin
                count_d = count_q + 1'b1;
                state_d = (count_q == LAST_CNT) ? S_FULL : S_EMPTY;
            end
            if (accept) begin
                if (legal) begin
                    wdata_d = word;
                    state_d = S_PEND;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = (state_q == S_PEND);
    assign mem_addr  = count_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign full      = (state_q == S_FULL);
    assign err       = err_q;
endmodule
